// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-enable driven h/v counters with registered
// sync, display-enable and coordinate outputs lagging the counters by one pixel.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int unsigned CNT_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] px_x,
    output logic [CNT_W-1:0] px_y,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL    = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_BEG = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_END = H_VISIBLE + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_END = V_VISIBLE + V_FP + V_SYNC;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             h_wrap;
    logic             de_c;
    logic             hs_act_c;
    logic             vs_act_c;
    logic             origin_c;

    // Counter advance and decode of the current (pre-increment) position
    always_comb begin
        h_wrap   = (32'(h_cnt) == H_TOTAL - 1);
        h_nxt    = h_wrap ? '0 : h_cnt + CNT_W'(1);
        v_nxt    = v_cnt;
        if (h_wrap) begin
            v_nxt = (32'(v_cnt) == V_TOTAL - 1) ? '0 : v_cnt + CNT_W'(1);
        end
        de_c     = (32'(h_cnt) < H_VISIBLE) && (32'(v_cnt) < V_VISIBLE);
        hs_act_c = (32'(h_cnt) >= H_SYNC_BEG) && (32'(h_cnt) < H_SYNC_END);
        vs_act_c = (32'(v_cnt) >= V_SYNC_BEG) && (32'(v_cnt) < V_SYNC_END);
        origin_c = (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (ce) begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Outputs register the decode on the same ce edge the counters advance
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= ce && origin_c;
            if (ce) begin
                hsync <= hs_act_c ? HS_POL : ~HS_POL;
                vsync <= vs_act_c ? VS_POL : ~VS_POL;
                de    <= de_c;
                px_x  <= de_c ? h_cnt : '0;
                px_y  <= de_c ? v_cnt : '0;
            end
        end
    end

endmodule
